step_pulse_driver: RTL
======================

STEP_PULSE_DRIVER -- requirements
Module: step_pulse_driver

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: dir-to-step setup cycles on direction change.
REQ-002 SHALL have parameter HIGH_CYC, default 4: step high width in cycles, >=1.
REQ-003 SHALL have parameter LOW_CYC, default 4: step low width in cycles, >=1.
REQ-004 SHALL have parameter QDEPTH, default 8: per-axis pending-step FIFO depth, power of 2.
REQ-005 SHALL have ports, one clock; reset is synchronous and active-high:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 start  in  1  interpolator running; qualifies step inputs
 Ax / fAx  in  1 each  +X / -X step request, one-cycle pulse
 Ay / fAy  in  1 each  +Y / -Y step request, one-cycle pulse
 load  in  1  load position registers
 ld_x / ld_y  in  32 each  signed load values
 step_x / step_y  out  1 each  motor step pulses
 dir_x / dir_y  out  1 each  1 = positive, 0 = negative
 pos_x / pos_y  out  32 each  signed absolute position
 busy  out  1  any FIFO non-empty or any axis FSM not IDLE
 done  out  1  one-cycle completion pulse
 err_x / err_y  out  1 each  sticky: conflicting request (+ and - in same cycle)
 ovf_x / ovf_y  out  1 each  sticky: request dropped, FIFO full

Function
REQ-006 SHALL push dir bit 1 on Ax and 0 on fAx into the X FIFO when start=1; likewise Ay/fAy into Y.
REQ-007 SHALL ignore step inputs while start=0.
REQ-008 SHALL push nothing and set err_x when Ax and fAx are both 1 with start=1; same for Y.
REQ-009 SHALL drop the request and set ovf_x when the X FIFO is full; a pop in the same cycle does not free space for that push; same for Y.
REQ-010 SHALL run an independent FSM per axis: IDLE, SETUP, STEP_HIGH, STEP_LOW.
REQ-011 IDLE with FIFO non-empty SHALL pop the entry; if it equals the current dir, go to STEP_HIGH; else update dir in that cycle and go to SETUP.
REQ-012 SETUP SHALL last exactly SETUP_CYC cycles, then STEP_HIGH.
REQ-013 STEP_HIGH SHALL drive step=1 for exactly HIGH_CYC cycles, then STEP_LOW.
REQ-014 STEP_LOW SHALL drive step=0 for exactly LOW_CYC cycles, then IDLE.
REQ-015 dir SHALL be stable throughout SETUP, STEP_HIGH and STEP_LOW.
REQ-016 Latency, empty FIFO, same direction: request sampled at edge t, pop at edge t+1, step_x high after edge t+2; with a direction change, high after edge t+2+SETUP_CYC.
REQ-017 pos SHALL change by +1 or -1 on the edge entering STEP_HIGH, wrapping modulo 2^32.
REQ-018 load SHALL set pos_x=ld_x and pos_y=ld_y when busy=0 and start=0; otherwise it is ignored.
REQ-019 done SHALL pulse for one cycle on the first cycle where start=0, busy=0 and the block is armed; arming is set by start=1 and cleared by done.
REQ-020 Both axes SHALL step concurrently without mutual stalls.

Reset
REQ-021 On reset: step=0, dir=0, pos=0, FSMs IDLE, FIFOs empty, busy=0, done=0, all sticky flags 0, arm cleared.
REQ-022 Reset mid-pulse SHALL drop step low on the next edge and discard pending steps.

Structure
REQ-023 Shared package SHALL hold the FSM state enum and the parameter defaults.
REQ-024 Per-axis logic (FIFO, FSM, position counter, flags) SHALL be a sub-module step_axis_gen, instantiated twice.

Verification
REQ-025 Single Ax pulse with start=1 after reset -> dir_x stays 0 then goes 1, SETUP 2 cycles, step_x high 4 cycles, pos_x=1, then done one cycle after start drops.
REQ-026 Three fAx pulses 1 cycle apart, dir_x already 0 -> three step_x pulses, each 4 high/4 low, no SETUP, pos_x=-3, no ovf_x.
REQ-027 Ax and fAx high in the same cycle -> no step_x, pos_x unchanged, err_x=1 until reset.
REQ-028 Ten Ay pulses back-to-back -> 8 queued, 1 popped, 1 dropped, ovf_y=1, pos_y=9 at finish.
REQ-029 load with ld_x=100, ld_y=-5 while idle, then one fAy -> pos_x=100, pos_y=-6; load while busy=1 -> ignored.
REQ-030 reset asserted during STEP_HIGH with 3 steps queued -> step_x=0 next cycle, busy=0, pos_x=0, no further pulses.

Source files
------------

// File: rtl/step_pulse_driver_pkg.sv
// Shared types and parameter defaults for the two-axis step/direction pulse driver.
package step_pulse_driver_pkg;

    localparam int unsigned SETUP_CYC_DEF = 2;
    localparam int unsigned HIGH_CYC_DEF  = 4;
    localparam int unsigned LOW_CYC_DEF   = 4;
    localparam int unsigned QDEPTH_DEF    = 8;
    localparam int unsigned POS_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } axis_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/step_pulse_driver_step_axis_gen.sv
// One motion axis: pending-step FIFO, step/dir pulse FSM, position counter and sticky flags.
module step_axis_gen
    import step_pulse_driver_pkg::*;
#(
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
    parameter int unsigned HIGH_CYC  = HIGH_CYC_DEF,
    parameter int unsigned LOW_CYC   = LOW_CYC_DEF,
    parameter int unsigned QDEPTH    = QDEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    req_pos,
    input  logic                    req_neg,
    input  logic                    load_en,
    input  logic signed [POS_W-1:0] ld_val,
    output logic                    step,
    output logic                    dir,
    output logic signed [POS_W-1:0] pos,
    output logic                    busy,
    output logic                    err,
    output logic                    ovf
);

    localparam int unsigned AW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_MAX = max3(SETUP_CYC, HIGH_CYC, LOW_CYC);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    axis_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          dir_next;
    logic          pop;

    logic [QDEPTH-1:0] fifo_mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_next;
    logic              fifo_full, fifo_empty, req_one, push, head;

    assign fifo_full  = (count == (AW+1)'(QDEPTH));
    assign fifo_empty = (count == '0);
    assign req_one    = req_pos ^ req_neg;
    // Fullness is judged before any same-cycle pop, so a pop never makes room for this push.
    assign push       = start && req_one && !fifo_full;
    assign head       = fifo_mem[rd_ptr];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    dir_next = head;
                    if ((head == dir) || (SETUP_CYC == 0)) begin
                        state_next = ST_HIGH;
                        cnt_next   = CW'(HIGH_CYC - 1);
                    end else begin
                        state_next = ST_SETUP;
                        cnt_next   = CW'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = ST_HIGH;
                    cnt_next   = CW'(HIGH_CYC - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    state_next = ST_LOW;
                    cnt_next   = CW'(LOW_CYC - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_LOW: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!push && pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // step is a registered image of the HIGH state, hence one cycle behind the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dir   <= dir_next;
            step  <= (state == ST_HIGH);
            busy  <= (count_next != '0) || (state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= '0;
            err <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if ((state_next == ST_HIGH) && (state != ST_HIGH)) begin
                pos <= dir_next ? (pos + POS_W'(1)) : (pos - POS_W'(1));
            end else if (load_en) begin
                pos <= ld_val;
            end
            err <= err | (start & req_pos & req_neg);
            ovf <= ovf | (start & req_one & fifo_full);
        end
    end

endmodule

// File: rtl/step_pulse_driver.sv
// Two-axis step/direction pulse driver with position tracking and run-completion pulse.
module step_pulse_driver
    import step_pulse_driver_pkg::*;
#(
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
    parameter int unsigned HIGH_CYC  = HIGH_CYC_DEF,
    parameter int unsigned LOW_CYC   = LOW_CYC_DEF,
    parameter int unsigned QDEPTH    = QDEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    Ax,
    input  logic                    fAx,
    input  logic                    Ay,
    input  logic                    fAy,
    input  logic                    load,
    input  logic signed [POS_W-1:0] ld_x,
    input  logic signed [POS_W-1:0] ld_y,
    output logic                    step_x,
    output logic                    step_y,
    output logic                    dir_x,
    output logic                    dir_y,
    output logic signed [POS_W-1:0] pos_x,
    output logic signed [POS_W-1:0] pos_y,
    output logic                    busy,
    output logic                    done,
    output logic                    err_x,
    output logic                    err_y,
    output logic                    ovf_x,
    output logic                    ovf_y
);

    logic busy_x, busy_y, load_en, armed, done_c;

    assign busy    = busy_x | busy_y;
    assign load_en = load && !start && !busy;
    assign done_c  = armed && !start && !busy;

    step_axis_gen #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .LOW_CYC   (LOW_CYC),
        .QDEPTH    (QDEPTH)
    ) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .req_pos (Ax),
        .req_neg (fAx),
        .load_en (load_en),
        .ld_val  (ld_x),
        .step    (step_x),
        .dir     (dir_x),
        .pos     (pos_x),
        .busy    (busy_x),
        .err     (err_x),
        .ovf     (ovf_x)
    );

    step_axis_gen #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .LOW_CYC   (LOW_CYC),
        .QDEPTH    (QDEPTH)
    ) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .req_pos (Ay),
        .req_neg (fAy),
        .load_en (load_en),
        .ld_val  (ld_y),
        .step    (step_y),
        .dir     (dir_y),
        .pos     (pos_y),
        .busy    (busy_y),
        .err     (err_y),
        .ovf     (ovf_y)
    );

    // A run is armed by start and reported once, when start is low and both axes are drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            done  <= 1'b0;
        end else begin
            done  <= done_c;
            armed <= start | (armed & !done_c);
        end
    end

endmodule
